// File: rtl/clk_div_pkg.sv
// Shared constants for the clock-divider family: board clock, default divisor
// and half-period divisors for the rates the board commonly needs.
package clk_div_pkg;

  localparam int unsigned CLK_FREQ_HZ = 50_000_000;
  localparam int unsigned DEF_WIDTH   = 25;

  localparam logic [24:0] DEF_DIV = 25'd25000000;

  // Half-period divisors: the output period is 2*D input cycles.
  localparam int unsigned DIV_1HZ       = 25_000_000;
  localparam int unsigned DIV_1KHZ      = 25_000;
  localparam int unsigned DIV_9600_BAUD = 2_604;

  function automatic int unsigned half_div(input int unsigned freq_hz);
    return CLK_FREQ_HZ / (2 * freq_hz);
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control/status bundle between a host and the multi-channel clock divider.
interface clk_div_multi_if
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NCH   = 4,
  parameter int unsigned CHW   = 2
);

  logic [NCH-1:0]   en;
  logic             sync;
  logic             wr_en;
  logic [CHW-1:0]   wr_ch;
  logic [WIDTH-1:0] wr_div;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   upd_pend;

  modport master (
    output en, sync, wr_en, wr_ch, wr_div,
    input  clk_out, tick, upd_pend
  );

  modport slave (
    input  en, sync, wr_en, wr_ch, wr_div,
    output clk_out, tick, upd_pend
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, active/pending divisor and the
// registered square wave plus its rising-edge tick.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEF_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_div,
  output logic             clk_out,
  output logic             tick,
  output logic             upd_pend
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] d_act_q, d_act_d;
  logic [WIDTH-1:0] d_pend_q, d_pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;
  logic             apply;

  // Divisor changes only land at a half-period boundary (or while idle), so a
  // running half-period is never shortened.
  always_comb begin
    cnt_d    = cnt_q;
    clk_d    = clk_q;
    tick_d   = 1'b0;
    d_act_d  = d_act_q;
    d_pend_d = d_pend_q;
    pend_d   = pend_q;
    apply    = 1'b0;

    if (sync || !en || (d_act_q == '0)) begin
      cnt_d = '0;
      clk_d = 1'b0;
      apply = pend_q;
    end else if (cnt_q == d_act_q - ONE) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      tick_d = ~clk_q;
      apply  = pend_q;
    end else begin
      cnt_d = cnt_q + ONE;
    end

    if (apply) begin
      d_act_d = d_pend_q;
      pend_d  = 1'b0;
    end

    // A write on the apply edge is kept pending for the next boundary.
    if (wr_en) begin
      d_pend_d = wr_div;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
      d_act_q  <= DEFAULT_DIV;
      d_pend_q <= DEFAULT_DIV;
      pend_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
      d_act_q  <= d_act_d;
      d_pend_q <= d_pend_d;
      pend_q   <= pend_d;
    end
  end

  assign clk_out  = clk_q;
  assign tick     = tick_q;
  assign upd_pend = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// NCH independent programmable clock dividers sharing one clock, reset and
// sync pulse; divisor writes are steered to a single channel by wr_ch.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEF_DIV),
  parameter int unsigned      NCH         = 4,
  parameter int unsigned      CHW         = 2
) (
  input logic             clk_in,
  input logic             ar,
  clk_div_multi_if.slave  bus
);

  logic [NCH-1:0] wr_sel;
  logic [NCH-1:0] clk_out_w;
  logic [NCH-1:0] tick_w;
  logic [NCH-1:0] pend_w;

  // Indices at or above NCH match no channel, so such writes are dropped.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.wr_en && (bus.wr_ch == CHW'(i))) begin
        wr_sel[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clk_div_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk      (clk_in),
      .rst_n    (ar),
      .en       (bus.en[g]),
      .sync     (bus.sync),
      .wr_en    (wr_sel[g]),
      .wr_div   (bus.wr_div),
      .clk_out  (clk_out_w[g]),
      .tick     (tick_w[g]),
      .upd_pend (pend_w[g])
    );
  end

  assign bus.clk_out  = clk_out_w;
  assign bus.tick     = tick_w;
  assign bus.upd_pend = pend_w;

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised, multi-channel successor to the single fixed-ratio clock divider.
- Generates NCH independent divided square waves from one input clock, plus a one-cycle tick strobe per channel.
- Each channel's half-period divisor is programmable at run time. Updates are glitch-free and take effect at a half-period boundary.
- A common sync input phase-aligns all channels. Used as the board-level tick/clock-enable source (1 Hz displays, scan clocks, baud ticks).

Parameters:
- WIDTH, 25, bit width of divisor and per-channel counter.
- DEFAULT_DIV, 25'd25000000, divisor loaded into every channel at reset (1 Hz out from 50 MHz in).
- NCH, 4, number of output channels (1..16).
- CHW, 2, width of channel-select field; must satisfy 2**CHW >= NCH.

Ports:
- clk_in  input  1  system clock (50 MHz on board).
- ar  input  1  synchronous active-low reset, sampled on rising clk_in.
- en  input  NCH  per-channel enable, active high.
- sync  input  1  one-cycle pulse; restarts all channels in phase.
- wr_en  input  1  divisor write strobe.
- wr_ch  input  CHW  channel index for the write.
- wr_div  input  WIDTH  new half-period divisor D.
- clk_out  output  NCH  divided square waves.
- tick  output  NCH  one-cycle pulse coincident with each clk_out rising transition.
- upd_pend  output  NCH  high while a written divisor has not yet been applied.

Behaviour:
- All state changes on rising clk_in. All outputs are registered.
- Reset (ar==0 at an edge) per channel:
  - cnt=0, clk_out=0, tick=0, D_act=DEFAULT_DIV, D_pend=DEFAULT_DIV, upd_pend=0.
  - Reset asserted mid-operation aborts the current half-period.
- Counting (en=1, D_act>=1):
  - If cnt==D_act-1: cnt<=0 and clk_out toggles. Otherwise cnt<=cnt+1.
  - Output period is 2*D_act input cycles with 50% duty.
  - After reset release or enable, the first clk_out rise occurs on the D_act-th edge.
- tick<=1 in exactly the cycle clk_out goes 0->1, else 0. Its rise aligns with the clk_out rise.
- D_act==1: clk_out toggles every edge (clk_in/2). tick is high every other cycle.
- D_act==0: channel stalls with cnt=0, clk_out=0, tick=0. Pending updates still apply immediately.
- Disable (en=0): next edge sets cnt=0, clk_out=0, tick=0. When re-enabled, counting starts from 0.
- Divisor write (wr_en=1):
  - D_pend[wr_ch]<=wr_div and upd_pend[wr_ch]<=1.
  - A wr_ch >= NCH is ignored.
- Divisor apply:
  - When upd_pend=1 and the channel is at a terminal count (cnt==D_act-1 with en=1), D_act<=D_pend and upd_pend<=0 on that edge.
  - The apply also happens on the first edge where en=0 or D_act==0.
  - A new D never truncates a half-period in progress.
- Write and apply on the same edge: the applied value is the D_pend held before the edge. The new write is captured and upd_pend stays 1, so it applies at the next boundary.
- Back-to-back writes to one channel before an apply: the last write wins.
- sync=1: every channel sets cnt=0, clk_out=0, tick=0. Pending divisors apply if upd_pend=1.
- Priority: ar > sync > en=0 > terminal count > increment.
- Counter width: cnt is WIDTH bits. It never wraps because the compare fires at D_act-1 <= 2**WIDTH-2.

Decomposition:
- Shared package/header clk_div_pkg:
  - Default divisor constant.
  - Board clock frequency constant (50_000_000).
  - Helper constants for common rates: 1 Hz, 1 kHz, 9600-baud tick.
- Sub-module clk_div_chan (one channel: cnt, D_act, D_pend, upd_pend, clk_out, tick), instantiated NCH times in a generate loop.
- The top level decodes wr_ch into per-channel write strobes and fans out sync and ar.

Test Plan:
- WIDTH=4, DEFAULT_DIV=3, NCH=2, en=2'b11 after reset: clk_out[0] rises on the 3rd edge after ar release. Period is 6 cycles, high 3, low 3. tick[0] is high once per 6 cycles, aligned with the rise.
- Write wr_ch=1, wr_div=5 mid-half-period:
  - upd_pend[1]=1 until the current half-period completes at 3 cycles.
  - Afterwards the period is 10 cycles. No high or low phase is shorter than 3 cycles.
  - Channel 0 is unaffected.
- Write D=0 to ch0, then D=1: ch0 holds 0 with no ticks. After D=1 applies, clk_out[0] toggles every cycle and tick[0] fires every 2 cycles.
- Write on the exact terminal-count edge (D_act=3, D_pend=4, new write 6): D_act becomes 4 at that edge, upd_pend stays 1, and D_act becomes 6 at the following boundary.
- Channels set to D=3 and D=5, then a sync pulse: both clk_out go to 0 next cycle and both rise together 3 and 5 edges later respectively. en[1]=0 forces clk_out[1]=0 in 1 cycle.
- Assert ar=0 mid-count with pending writes: next edge has all outputs 0, D_act=DEFAULT_DIV, and upd_pend=0. A wr_ch=3 write with NCH=2 leaves all state unchanged.
